// File: rtl/instruction_memory.sv
// Word-organised instruction store: combinational byte-addressed fetch, synchronous load port.
// Zero-latency read; load writes on the rising edge; no backpressure, every load is accepted or flagged.
module instruction_memory #(
    parameter int    Isize     = 32,
    parameter int    mem_size  = 10,
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Isize-1:0] address,
    output logic [Isize-1:0] instruction,
    output logic             addr_err,
    output logic             misaligned,
    input  logic             load_en,
    input  logic [Isize-1:0] load_addr,
    input  logic [Isize-1:0] load_data,
    output logic             load_err
);

    localparam int               IW       = Isize - 2;
    localparam int               AW       = (mem_size > 1) ? $clog2(mem_size) : 1;
    localparam logic [IW-1:0]    DEPTH    = IW'(mem_size);

    logic [Isize-1:0] mem [mem_size];

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] ld_idx;
    logic          rd_in_range;
    logic          ld_in_range;
    logic          unused_ld_low;

    // The full word index is compared against the depth, so large addresses never alias.
    assign rd_idx      = address[Isize-1:2];
    assign ld_idx      = load_addr[Isize-1:2];
    assign rd_in_range = (rd_idx < DEPTH);
    assign ld_in_range = (ld_idx < DEPTH);
    assign unused_ld_low = ^load_addr[1:0];

    always_comb begin
        instruction = '0;
        if (rd_in_range) begin
            instruction = mem[rd_idx[AW-1:0]];
        end
    end

    assign addr_err   = ~rd_in_range;
    assign misaligned = (address[1:0] != 2'b00);

    // Reset clears the store and always takes priority over a pending load.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < mem_size; i++) begin
                mem[i] <= '0;
            end
        end else if (load_en && ld_in_range) begin
            mem[ld_idx[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_err <= 1'b0;
        end else if (load_en) begin
            load_err <= ~ld_in_range;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory with a scoreboard queue of expected fetch results.
module tb_instruction_memory;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        addr_err;
    logic        misaligned;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        aerr;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [N];
    logic        model_lerr;
    int          total = 0;
    int          bad   = 0;

    instruction_memory #(.Isize(32), .mem_size(N), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .address(address), .instruction(instruction),
        .addr_err(addr_err), .misaligned(misaligned), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t predict(input logic [31:0] a);
        exp_t e;
        logic [29:0] idx;
        idx     = a[31:2];
        e.addr  = a;
        e.aerr  = (idx >= 30'(N));
        e.instr = e.aerr ? 32'h0 : model[idx];
        e.mis   = (a[1:0] != 2'b00);
        return e;
    endfunction

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive a fetch address, queue its prediction, then compare once the comb path settles.
    task automatic fetch(input logic [31:0] a);
        exp_t e;
        address = a;
        sb.push_back(predict(a));
        #2;
        e = sb.pop_front();
        check_word($sformatf("instr@%h", e.addr), instruction, e.instr);
        check_bit($sformatf("addr_err@%h", e.addr), addr_err, e.aerr);
        check_bit($sformatf("misaligned@%h", e.addr), misaligned, e.mis);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk);
        if (a[31:2] < 30'(N)) begin
            model[a[31:2]] = d;
            model_lerr     = 1'b0;
        end else begin
            model_lerr = 1'b1;
        end
        #1;
        load_en = 1'b0;
        check_bit($sformatf("load_err after load @%h", a), load_err, model_lerr);
    endtask

    task automatic do_reset(input logic with_load);
        @(negedge clk);
        reset     = 1'b1;
        load_en   = with_load;
        load_addr = 32'h0;
        load_data = 32'hFFFF_FFFF;
        @(posedge clk);
        for (int i = 0; i < N; i++) model[i] = 32'h0;
        model_lerr = 1'b0;
        #1;
        reset   = 1'b0;
        load_en = 1'b0;
        check_bit("load_err after reset", load_err, model_lerr);
    endtask

    initial begin
        reset     = 1'b0;
        address   = 32'h0;
        load_en   = 1'b0;
        load_addr = 32'h0;
        load_data = 32'h0;
        model_lerr = 1'b0;

        do_reset(1'b0);
        fetch(32'd0);
        fetch(32'd4);
        fetch(32'd8);

        do_load(32'd0, 32'hDEAD_BEEF);
        do_load(32'd4, 32'h1234_5678);
        do_load(32'd8, 32'h0000_0013);
        @(negedge clk);
        fetch(32'd0);
        #8 fetch(32'd4);
        #8 fetch(32'd8);

        fetch(32'd40);
        fetch(32'd36);
        fetch(32'd5);
        fetch(32'd6);
        fetch(32'd39);
        fetch(32'hFFFF_FFFC);

        do_load(32'd44, 32'hAAAA_5555);
        for (int a = 0; a < 4 * N; a += 4) fetch(32'(a));
        @(negedge clk);
        @(negedge clk);
        check_bit("load_err holds while idle", load_err, model_lerr);
        do_load(32'd39, 32'hCAFE_F00D);
        fetch(32'd36);

        do_reset(1'b1);
        fetch(32'd0);
        fetch(32'd36);

        for (int k = 0; k < 12; k++) begin
            do_load($urandom_range(0, 4 * N + 11), $urandom);
            @(negedge clk);
            fetch($urandom_range(0, 4 * N + 7));
        end
        for (int a = 0; a < 4 * N; a += 4) begin
            @(negedge clk);
            fetch(32'(a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
